mem_access_ctrl: RTL and testbench
==================================

MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 SHALL have one clock and an asynchronous, active-high reset: clk  input  1  rising-edge clock; rst  input  1  asynchronous active-high reset.
REQ-002 SHALL have Addr_in  input  16  memory address from EX/MEM (ALU result).
REQ-003 SHALL have WriteData_in  input  16  store data from EX/MEM.
REQ-004 SHALL have MemRead_in / MemWrite_in  input  1 each  access request from EX/MEM.
REQ-005 SHALL have mem_en_out / mem_wr_out  output  1 each  memory request strobe / write select.
REQ-006 SHALL have mem_addr_out / mem_wdata_out  output  16 each  latched address / latched store data.
REQ-007 SHALL have mem_busy_in  input  1  memory refuses request this cycle.
REQ-008 SHALL have mem_done_in / mem_rdata_in  input  1 / 16  access complete / read data.
REQ-009 SHALL have stall_out  output  1  freeze IF..EX/MEM.
REQ-010 SHALL have ReadData_out  output  16  load result to MEM/WB.
REQ-011 SHALL have err_out  output  1  sticky access error.

Function
REQ-012 SHALL implement FSM states IDLE, REQ, WAIT, DONE.
REQ-013 IDLE: access = MemRead_in|MemWrite_in; on access, SHALL latch Addr_in, WriteData_in, op (write if MemWrite_in), and go to REQ.
REQ-014 MemRead_in and MemWrite_in both high SHALL be treated as a write.
REQ-015 REQ: mem_en_out=1 and mem_wr_out=latched op; if mem_busy_in=1, SHALL stay in REQ and re-present the same request; otherwise SHALL go to WAIT.
REQ-016 mem_done_in SHALL be ignored in REQ and in IDLE.
REQ-017 WAIT: on mem_done_in=1, SHALL go to DONE; for reads, SHALL capture mem_rdata_in into ReadData_out on that edge.
REQ-018 WAIT SHALL run a 4-bit timeout counter, cleared on entry; the counter reaching 15 without mem_done_in SHALL set err_out, force ReadData_out=0, and go to DONE.
REQ-019 DONE: lasts exactly one cycle, SHALL ignore all inputs, then go to IDLE (prevents re-issue of the same held instruction).
REQ-020 stall_out SHALL be combinational = (IDLE & access & ~drop) | REQ | WAIT; 0 in DONE.
REQ-021 Minimum access latency: detect in IDLE (cycle 0), REQ (cycle 1), WAIT with done (cycle 2), DONE (cycle 3, stall low).
REQ-022 mem_addr_out / mem_wdata_out SHALL hold their latched values until the next IDLE latch.
REQ-023 ReadData_out SHALL hold its value across writes and idle cycles.
REQ-024 err_out, once set, SHALL remain 1 until reset.

Reset
REQ-025 rst SHALL act asynchronously from any state: FSM to IDLE; counter 0; mem_en_out, mem_wr_out, stall_out (while no access pending), and err_out 0; mem_addr_out, mem_wdata_out, and ReadData_out 0x0000.
REQ-026 A reset asserted mid-access SHALL drop mem_en_out in the same cycle, with no completion reported.

Configuration
REQ-027 With MEM_ALIGN_CHK_EN defined: an IDLE access with Addr_in[0]=1 SHALL be dropped, with no request issued, no stall, and err_out set next edge.
REQ-028 Without MEM_ALIGN_CHK_EN: Addr_in[0] SHALL be ignored for checking and passed unchanged; err_out SHALL be set only by timeout.

Verification
REQ-029 Load with Addr_in=0x0010, busy=0, done in the cycle after REQ, rdata=0xBEEF -> stall high for 3 cycles, one mem_en_out pulse, ReadData_out=0xBEEF in DONE.
REQ-030 Store with Addr_in=0x0020, WriteData_in=0x1234, busy=1 for 2 cycles -> mem_en_out high 3 consecutive cycles with mem_wr_out=1 and mem_wdata_out=0x1234; ReadData_out unchanged.
REQ-031 Load with done never asserted -> err_out=1 after 15 WAIT cycles, ReadData_out=0x0000, stall released in DONE.
REQ-032 rst pulsed during WAIT -> mem_en_out=0 and state IDLE immediately; a later done pulse is ignored.
REQ-033 Load with Addr_in=0x0011 -> with MEM_ALIGN_CHK_EN: no mem_en_out, stall_out=0, err_out=1; without it: normal access, err_out=0.

Source files
------------

// File: rtl/mem_access_ctrl.sv
// -----------------------------------------------------------------------------
// mem_access_ctrl
// Sequences one data-memory access per load/store instruction in the EX/MEM
// stage. While an access is in flight it freezes the front of the pipeline.
// It then returns load data to MEM/WB.
//
// Optional build macro: MEM_ALIGN_CHK_EN
//   When defined, an access to an odd address is dropped in IDLE and sets
//   err_out. When undefined, address bit 0 is passed through unchecked.
//
// Ports
//   clk, rst                    clock, asynchronous active-high reset
//   Addr_in, WriteData_in       address / store data from EX/MEM
//   MemRead_in, MemWrite_in     access request from EX/MEM (both = write)
//   mem_en_out, mem_wr_out      memory request strobe / write select
//   mem_addr_out, mem_wdata_out latched address / store data
//   mem_busy_in                 memory refuses the request this cycle
//   mem_done_in, mem_rdata_in   access complete / read data
//   stall_out                   freeze IF..EX/MEM (combinational)
//   ReadData_out                load result to MEM/WB
//   err_out                     sticky error (timeout, or misalignment)
// -----------------------------------------------------------------------------
module mem_access_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] Addr_in,
  input  logic [15:0] WriteData_in,
  input  logic        MemRead_in,
  input  logic        MemWrite_in,
  output logic        mem_en_out,
  output logic        mem_wr_out,
  output logic [15:0] mem_addr_out,
  output logic [15:0] mem_wdata_out,
  input  logic        mem_busy_in,
  input  logic        mem_done_in,
  input  logic [15:0] mem_rdata_in,
  output logic        stall_out,
  output logic [15:0] ReadData_out,
  output logic        err_out
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

  state_t     state_reg;
  logic [3:0] cnt_reg;
  logic       op_write_reg;
  logic       access;
  logic       drop;

  assign access = MemRead_in | MemWrite_in;

`ifdef MEM_ALIGN_CHK_EN
  assign drop = Addr_in[0];
`else
  assign drop = 1'b0;
`endif

  // Stall is combinational so the pipeline freezes in the very cycle the
  // access is detected. It is released in DONE, which lets the held
  // instruction retire.
  assign stall_out = ((state_reg == S_IDLE) & access & ~drop) |
                     (state_reg == S_REQ) | (state_reg == S_WAIT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= S_IDLE;
      cnt_reg       <= 4'd0;
      op_write_reg  <= 1'b0;
      mem_en_out    <= 1'b0;
      mem_wr_out    <= 1'b0;
      mem_addr_out  <= 16'h0000;
      mem_wdata_out <= 16'h0000;
      ReadData_out  <= 16'h0000;
      err_out       <= 1'b0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (access && drop) begin
            err_out <= 1'b1;
          end else if (access) begin
            mem_addr_out  <= Addr_in;
            mem_wdata_out <= WriteData_in;
            op_write_reg  <= MemWrite_in;
            // Strobe and write select are registered, so they become
            // valid exactly for the REQ cycles.
            mem_en_out    <= 1'b1;
            mem_wr_out    <= MemWrite_in;
            state_reg     <= S_REQ;
          end
        end
        S_REQ: begin
          // While busy, the strobe stays up and the request is re-presented.
          if (!mem_busy_in) begin
            mem_en_out <= 1'b0;
            mem_wr_out <= 1'b0;
            cnt_reg    <= 4'd0;
            state_reg  <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (mem_done_in) begin
            if (!op_write_reg)
              ReadData_out <= mem_rdata_in;
            state_reg <= S_DONE;
          end else if (cnt_reg == 4'd14) begin
            // The counter reaches 15 at the end of the 15th WAIT cycle
            // that has no completion.
            cnt_reg      <= 4'd15;
            err_out      <= 1'b1;
            ReadData_out <= 16'h0000;
            state_reg    <= S_DONE;
          end else begin
            cnt_reg <= cnt_reg + 4'd1;
          end
        end
        S_DONE: begin
          state_reg <= S_IDLE;
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
module tb_mem_access_ctrl;

  logic        clk;
  logic        rst;
  logic [15:0] Addr_in;
  logic [15:0] WriteData_in;
  logic        MemRead_in;
  logic        MemWrite_in;
  logic        mem_en_out;
  logic        mem_wr_out;
  logic [15:0] mem_addr_out;
  logic [15:0] mem_wdata_out;
  logic        mem_busy_in;
  logic        mem_done_in;
  logic [15:0] mem_rdata_in;
  logic        stall_out;
  logic [15:0] ReadData_out;
  logic        err_out;

  int checks = 0;
  int errors = 0;

  mem_access_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .Addr_in      (Addr_in),
    .WriteData_in (WriteData_in),
    .MemRead_in   (MemRead_in),
    .MemWrite_in  (MemWrite_in),
    .mem_en_out   (mem_en_out),
    .mem_wr_out   (mem_wr_out),
    .mem_addr_out (mem_addr_out),
    .mem_wdata_out(mem_wdata_out),
    .mem_busy_in  (mem_busy_in),
    .mem_done_in  (mem_done_in),
    .mem_rdata_in (mem_rdata_in),
    .stall_out    (stall_out),
    .ReadData_out (ReadData_out),
    .err_out      (err_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs are driven 2 time units after the rising edge. Checks happen
  // 1 unit later, well away from the next edge.
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic test_reset();
    rst = 1'b1; Addr_in = 16'h0; WriteData_in = 16'h0; MemRead_in = 1'b0;
    MemWrite_in = 1'b0; mem_busy_in = 1'b0; mem_done_in = 1'b0; mem_rdata_in = 16'h0;
    step(); step(); #1;
    checks++; if (mem_en_out !== 1'b0) begin errors++; $display("FAIL reset_en got %b exp 0", mem_en_out); end
    checks++; if (stall_out !== 1'b0) begin errors++; $display("FAIL reset_stall got %b exp 0", stall_out); end
    checks++; if (err_out !== 1'b0) begin errors++; $display("FAIL reset_err got %b exp 0", err_out); end
    checks++; if (mem_addr_out !== 16'h0000) begin errors++; $display("FAIL reset_addr got %h exp 0000", mem_addr_out); end
    checks++; if (ReadData_out !== 16'h0000) begin errors++; $display("FAIL reset_rdata got %h exp 0000", ReadData_out); end
    rst = 1'b0;
    $display("reset: outputs cleared");
  endtask

  task automatic test_load();
    step(); MemRead_in = 1'b1; Addr_in = 16'h0010; #1;   // IDLE detect
    checks++; if (stall_out !== 1'b1) begin errors++; $display("FAIL load_c0_stall got %b exp 1", stall_out); end
    checks++; if (mem_en_out !== 1'b0) begin errors++; $display("FAIL load_c0_en got %b exp 0", mem_en_out); end
    step(); #1;                                          // REQ
    checks++; if (mem_en_out !== 1'b1) begin errors++; $display("FAIL load_c1_en got %b exp 1", mem_en_out); end
    checks++; if (mem_wr_out !== 1'b0) begin errors++; $display("FAIL load_c1_wr got %b exp 0", mem_wr_out); end
    checks++; if (mem_addr_out !== 16'h0010) begin errors++; $display("FAIL load_c1_addr got %h exp 0010", mem_addr_out); end
    checks++; if (stall_out !== 1'b1) begin errors++; $display("FAIL load_c1_stall got %b exp 1", stall_out); end
    step(); mem_done_in = 1'b1; mem_rdata_in = 16'hBEEF; #1;  // WAIT with done
    checks++; if (mem_en_out !== 1'b0) begin errors++; $display("FAIL load_c2_en got %b exp 0", mem_en_out); end
    checks++; if (stall_out !== 1'b1) begin errors++; $display("FAIL load_c2_stall got %b exp 1", stall_out); end
    step(); mem_done_in = 1'b0; mem_rdata_in = 16'h0000; #1;  // DONE, request still held
    checks++; if (stall_out !== 1'b0) begin errors++; $display("FAIL load_c3_stall got %b exp 0", stall_out); end
    checks++; if (ReadData_out !== 16'hBEEF) begin errors++; $display("FAIL load_c3_rdata got %h exp beef", ReadData_out); end
    checks++; if (mem_en_out !== 1'b0) begin errors++; $display("FAIL load_c3_en got %b exp 0", mem_en_out); end
    step(); MemRead_in = 1'b0; #1;                       // back in IDLE
    checks++; if (stall_out !== 1'b0) begin errors++; $display("FAIL load_idle_stall got %b exp 0", stall_out); end
    $display("load: addr=0010 rdata=%h", ReadData_out);
  endtask

  task automatic test_store_busy();
    step(); MemWrite_in = 1'b1; Addr_in = 16'h0020; WriteData_in = 16'h1234; mem_busy_in = 1'b1; #1;
    checks++; if (stall_out !== 1'b1) begin errors++; $display("FAIL store_c0_stall got %b exp 1", stall_out); end
    for (int c = 1; c <= 3; c++) begin
      step();
      mem_done_in = (c == 1);          // a done pulse in REQ must be ignored
      mem_busy_in = (c < 3);
      #1;
      checks++; if (mem_en_out !== 1'b1) begin errors++; $display("FAIL store_c%0d_en got %b exp 1", c, mem_en_out); end
      checks++; if (mem_wr_out !== 1'b1) begin errors++; $display("FAIL store_c%0d_wr got %b exp 1", c, mem_wr_out); end
      checks++; if (mem_wdata_out !== 16'h1234) begin errors++; $display("FAIL store_c%0d_wdata got %h exp 1234", c, mem_wdata_out); end
    end
    step(); mem_done_in = 1'b1; mem_rdata_in = 16'hDEAD; #1;  // WAIT
    checks++; if (mem_en_out !== 1'b0) begin errors++; $display("FAIL store_wait_en got %b exp 0", mem_en_out); end
    step(); mem_done_in = 1'b0; MemWrite_in = 1'b0; #1;       // DONE
    checks++; if (stall_out !== 1'b0) begin errors++; $display("FAIL store_done_stall got %b exp 0", stall_out); end
    checks++; if (ReadData_out !== 16'hBEEF) begin errors++; $display("FAIL store_rdata got %h exp beef", ReadData_out); end
    $display("store: addr=0020 wdata=%h busy=2", mem_wdata_out);
  endtask

  task automatic test_back_to_back();
    // Starts in the IDLE cycle directly after the previous DONE.
    step(); MemRead_in = 1'b1; MemWrite_in = 1'b1; Addr_in = 16'h0022; WriteData_in = 16'h0001; #1;
    checks++; if (stall_out !== 1'b1) begin errors++; $display("FAIL b2b_c0_stall got %b exp 1", stall_out); end
    step(); #1;
    checks++; if (mem_wr_out !== 1'b1) begin errors++; $display("FAIL b2b_both_wr got %b exp 1", mem_wr_out); end
    checks++; if (mem_addr_out !== 16'h0022) begin errors++; $display("FAIL b2b_addr got %h exp 0022", mem_addr_out); end
    step(); MemRead_in = 1'b0; MemWrite_in = 1'b0; mem_done_in = 1'b1; mem_rdata_in = 16'h7777; #1;
    step(); mem_done_in = 1'b0; Addr_in = 16'h0999; #1;
    checks++; if (ReadData_out !== 16'hBEEF) begin errors++; $display("FAIL b2b_rdata got %h exp beef", ReadData_out); end
    step(); #1;
    checks++; if (mem_addr_out !== 16'h0022) begin errors++; $display("FAIL b2b_addr_hold got %h exp 0022", mem_addr_out); end
    $display("back_to_back: read+write treated as write, addr=%h", mem_addr_out);
  endtask

  task automatic test_timeout();
    int n;
    step(); MemRead_in = 1'b1; Addr_in = 16'h0030; #1;
    n = 0;
    while (stall_out === 1'b1 && n < 40) begin
      n++;
      step(); #1;
    end
    checks++; if (n !== 17) begin errors++; $display("FAIL timeout_stall_cycles got %0d exp 17", n); end
    checks++; if (err_out !== 1'b1) begin errors++; $display("FAIL timeout_err got %b exp 1", err_out); end
    checks++; if (ReadData_out !== 16'h0000) begin errors++; $display("FAIL timeout_rdata got %h exp 0000", ReadData_out); end
    step(); MemRead_in = 1'b0; #1;
    checks++; if (err_out !== 1'b1) begin errors++; $display("FAIL timeout_err_sticky got %b exp 1", err_out); end
    $display("timeout: stall cycles=%0d err=%b", n, err_out);
  endtask

  task automatic test_reset_mid_access();
    step(); MemRead_in = 1'b1; Addr_in = 16'h0040; #1;
    step(); MemRead_in = 1'b0; #1;                       // REQ
    step(); #1;                                          // WAIT
    checks++; if (stall_out !== 1'b1) begin errors++; $display("FAIL rstmid_wait_stall got %b exp 1", stall_out); end
    #2 rst = 1'b1;
    #1;
    checks++; if (stall_out !== 1'b0) begin errors++; $display("FAIL rstmid_stall got %b exp 0", stall_out); end
    checks++; if (mem_en_out !== 1'b0) begin errors++; $display("FAIL rstmid_en got %b exp 0", mem_en_out); end
    checks++; if (err_out !== 1'b0) begin errors++; $display("FAIL rstmid_err got %b exp 0", err_out); end
    checks++; if (mem_addr_out !== 16'h0000) begin errors++; $display("FAIL rstmid_addr got %h exp 0000", mem_addr_out); end
    #1 rst = 1'b0;
    step(); mem_done_in = 1'b1; mem_rdata_in = 16'hFFFF; #1;
    step(); mem_done_in = 1'b0; #1;
    checks++; if (ReadData_out !== 16'h0000) begin errors++; $display("FAIL rstmid_late_done got %h exp 0000", ReadData_out); end
    checks++; if (stall_out !== 1'b0) begin errors++; $display("FAIL rstmid_late_stall got %b exp 0", stall_out); end
    $display("reset_mid_access: aborted in WAIT, late done ignored");
  endtask

  task automatic test_align();
    step(); MemRead_in = 1'b1; Addr_in = 16'h0011; #1;
`ifdef MEM_ALIGN_CHK_EN
    checks++; if (stall_out !== 1'b0) begin errors++; $display("FAIL align_stall got %b exp 0", stall_out); end
    step(); MemRead_in = 1'b0; #1;
    checks++; if (mem_en_out !== 1'b0) begin errors++; $display("FAIL align_en got %b exp 0", mem_en_out); end
    checks++; if (err_out !== 1'b1) begin errors++; $display("FAIL align_err got %b exp 1", err_out); end
    $display("align: odd address dropped, err=%b", err_out);
`else
    checks++; if (stall_out !== 1'b1) begin errors++; $display("FAIL align_stall got %b exp 1", stall_out); end
    step(); #1;
    checks++; if (mem_en_out !== 1'b1) begin errors++; $display("FAIL align_en got %b exp 1", mem_en_out); end
    checks++; if (mem_addr_out !== 16'h0011) begin errors++; $display("FAIL align_addr got %h exp 0011", mem_addr_out); end
    step(); mem_done_in = 1'b1; mem_rdata_in = 16'h5A5A; #1;
    step(); mem_done_in = 1'b0; MemRead_in = 1'b0; #1;
    checks++; if (ReadData_out !== 16'h5A5A) begin errors++; $display("FAIL align_rdata got %h exp 5a5a", ReadData_out); end
    checks++; if (err_out !== 1'b0) begin errors++; $display("FAIL align_err got %b exp 0", err_out); end
    $display("align: odd address accessed normally, rdata=%h", ReadData_out);
`endif
  endtask

  initial begin
    test_reset();
    test_load();
    test_store_busy();
    test_back_to_back();
    test_timeout();
    test_reset_mid_access();
    test_align();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
